// File: rtl/pla_sweep_checker_if.sv
// Handshake and function-under-test bus between the harness and the sweep checker.
// The harness side (master) drives start/abort and returns the two function outputs;
// the checker side (slave) drives the vector and reports the sweep results.
interface pla_sweep_checker_if #(
    parameter int N_IN = 10
);
    logic              start;
    logic              abort;
    logic [N_IN-1:0]   vec;
    logic              y_a;
    logic              y_b;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     ones_a;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN-1:0]   first_mm_vec;
    logic              first_mm_valid;

    modport master (
        output start, abort, y_a, y_b,
        input  vec, busy, done, pass, ones_a, mismatch_cnt, first_mm_vec, first_mm_valid
    );

    modport slave (
        input  start, abort, y_a, y_b,
        output vec, busy, done, pass, ones_a, mismatch_cnt, first_mm_vec, first_mm_valid
    );
endinterface

// File: rtl/pla_sweep_checker.sv
// Exhaustive sweep sequencer: walks vec through 0..2^N_IN-1, samples two
// implementations of the same function LAT cycles later, and accumulates the
// onset count, mismatch count and the first mismatching vector.
module pla_sweep_checker #(
    parameter int N_IN             = 10,
    parameter int LAT              = 0,
    parameter int STOP_ON_MISMATCH = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pla_sweep_checker_if.slave     bus
);

    // A zero-latency build still declares one (unused, always invalid) tag stage.
    localparam int TAG_N = (LAT > 0) ? LAT : 1;
    localparam logic [N_IN-1:0] VEC_MAX  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_ZERO = {(N_IN+1){1'b0}};
    localparam logic [N_IN:0]   CNT_ONE  = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic [N_IN:0]     mm_cnt_q, mm_cnt_d;
    logic [N_IN-1:0]   fmm_vec_q, fmm_vec_d;
    logic              fmm_valid_q, fmm_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tag_v_q   [TAG_N];
    logic              tag_v_d   [TAG_N];
    logic [N_IN-1:0]   tag_vec_q [TAG_N];
    logic [N_IN-1:0]   tag_vec_d [TAG_N];

    logic              samp_s;
    logic [N_IN-1:0]   samp_vec_s;
    logic              take_s;
    logic              mm_s;
    logic              stop_hit_s;
    logic              flush_s;

    // Locate the sample point: the live vector at zero latency, else the pipeline tail.
    always_comb begin
        samp_s     = 1'b0;
        samp_vec_s = VEC_ZERO;
        if (LAT == 0) begin
            samp_s     = (state_q == S_RUN);
            samp_vec_s = vec_q;
        end else begin
            samp_s     = tag_v_q[TAG_N-1];
            samp_vec_s = tag_vec_q[TAG_N-1];
        end
    end

    // Next-state, accumulator, tag pipeline and registered-output computation.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        ones_d      = ones_q;
        mm_cnt_d    = mm_cnt_q;
        fmm_vec_d   = fmm_vec_q;
        fmm_valid_d = fmm_valid_q;
        flush_s     = 1'b0;

        // An abort edge takes no sample so the counters freeze exactly where they were.
        take_s     = samp_s && !bus.abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
        mm_s       = take_s && (bus.y_a != bus.y_b);
        stop_hit_s = (STOP_ON_MISMATCH != 0) && mm_s && !fmm_valid_q;

        if (take_s) begin
            ones_d = ones_q + {{N_IN{1'b0}}, bus.y_a};
        end else begin
            ones_d = ones_q;
        end
        if (mm_s) begin
            mm_cnt_d = mm_cnt_q + CNT_ONE;
        end else begin
            mm_cnt_d = mm_cnt_q;
        end
        if (mm_s && !fmm_valid_q) begin
            fmm_vec_d   = samp_vec_s;
            fmm_valid_d = 1'b1;
        end else begin
            fmm_vec_d   = fmm_vec_q;
            fmm_valid_d = fmm_valid_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.abort) begin
                    // Abort in IDLE is a no-op; in DONE it only drops done.
                    state_d = S_IDLE;
                    flush_s = 1'b1;
                end else if (bus.start) begin
                    state_d     = S_RUN;
                    vec_d       = VEC_ZERO;
                    ones_d      = CNT_ZERO;
                    mm_cnt_d    = CNT_ZERO;
                    fmm_vec_d   = VEC_ZERO;
                    fmm_valid_d = 1'b0;
                    flush_s     = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    flush_s = 1'b1;
                end else if (stop_hit_s) begin
                    state_d = S_DONE;
                    flush_s = 1'b1;
                end else if (vec_q == VEC_MAX) begin
                    // Last vector: hold it, let the pipeline drain if there is one.
                    vec_d = vec_q;
                    if (LAT == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    vec_d = vec_q + VEC_ONE;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    flush_s = 1'b1;
                end else if (stop_hit_s) begin
                    state_d = S_DONE;
                    flush_s = 1'b1;
                end else if (take_s && (samp_vec_s == VEC_MAX)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                flush_s = 1'b1;
            end
        endcase

        // Tag pipeline: a valid tag enters only while RUN issues a vector.
        if (flush_s) begin
            for (int i = 0; i < TAG_N; i++) begin
                tag_v_d[i]   = 1'b0;
                tag_vec_d[i] = tag_vec_q[i];
            end
        end else begin
            tag_v_d[0]   = (LAT > 0) && (state_q == S_RUN);
            tag_vec_d[0] = vec_q;
            for (int i = 1; i < TAG_N; i++) begin
                tag_v_d[i]   = tag_v_q[i-1];
                tag_vec_d[i] = tag_vec_q[i-1];
            end
        end

        if ((state_d == S_RUN) || (state_d == S_DRAIN)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
            pass_d = (mm_cnt_d == CNT_ZERO);
        end else begin
            done_d = 1'b0;
            pass_d = 1'b0;
        end
    end

    // State, accumulator, tag and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= VEC_ZERO;
            ones_q      <= CNT_ZERO;
            mm_cnt_q    <= CNT_ZERO;
            fmm_vec_q   <= VEC_ZERO;
            fmm_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            for (int i = 0; i < TAG_N; i++) begin
                tag_v_q[i]   <= 1'b0;
                tag_vec_q[i] <= VEC_ZERO;
            end
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            ones_q      <= ones_d;
            mm_cnt_q    <= mm_cnt_d;
            fmm_vec_q   <= fmm_vec_d;
            fmm_valid_q <= fmm_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            for (int i = 0; i < TAG_N; i++) begin
                tag_v_q[i]   <= tag_v_d[i];
                tag_vec_q[i] <= tag_vec_d[i];
            end
        end
    end

    assign bus.vec            = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.ones_a         = ones_q;
    assign bus.mismatch_cnt   = mm_cnt_q;
    assign bus.first_mm_vec   = fmm_vec_q;
    assign bus.first_mm_valid = fmm_valid_q;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Directed bench for pla_sweep_checker: three instances (LAT=0, LAT=2,
// LAT=0 with stop-on-mismatch) share one clock and reset.
module tb_pla_sweep_checker;

    logic clk;
    logic rst_n;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    logic inj0;
    logic inj2;
    logic [9:0] d1;
    logic [9:0] d2;
    int tests;
    int fails;
    int cyc;
    bit ovl;

    pla_sweep_checker_if #(.N_IN(10)) b0 ();
    pla_sweep_checker_if #(.N_IN(10)) b2 ();
    pla_sweep_checker_if #(.N_IN(10)) bs ();

    pla_sweep_checker #(.N_IN(10), .LAT(0), .STOP_ON_MISMATCH(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    pla_sweep_checker #(.N_IN(10), .LAT(2), .STOP_ON_MISMATCH(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    pla_sweep_checker #(.N_IN(10), .LAT(0), .STOP_ON_MISMATCH(1)) us (.clk(clk), .rst_n(rst_n), .bus(bs));

    assign b0.start = start_v[0];
    assign b2.start = start_v[1];
    assign bs.start = start_v[2];
    assign b0.abort = abort_v[0];
    assign b2.abort = abort_v[1];
    assign bs.abort = abort_v[2];

    // Instance 0: parity function, candidate optionally wrong at 0x2A5.
    assign b0.y_a = ^b0.vec;
    assign b0.y_b = (^b0.vec) ^ (inj0 && (b0.vec == 10'h2A5));

    // Instance 2: two-cycle delayed model of a constant-1 function.
    always @(posedge clk) begin
        d1 <= b2.vec;
        d2 <= d1;
    end
    assign b2.y_a = 1'b1;
    assign b2.y_b = ~(inj2 && (d2 == 10'h155));

    // Stop instance: candidate wrong at 0x010 and 0x020.
    assign bs.y_a = 1'b0;
    assign bs.y_b = (bs.vec == 10'h010) || (bs.vec == 10'h020);

    logic [2:0] done_w;
    logic [2:0] busy_w;
    assign done_w = {bs.done, b2.done, b0.done};
    assign busy_w = {bs.busy, b2.busy, b0.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on one instance and count cycles until done (bounded).
    task automatic run_sweep(input int idx, input int budget, output int n, output bit overlap);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        n = 0;
        overlap = 1'b0;
        while (!done_w[idx] && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
            if (busy_w[idx] && done_w[idx]) overlap = 1'b1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start_v = 3'b000;
        abort_v = 3'b000;
        inj0 = 1'b0;
        inj2 = 1'b0;
        #12;
        check("rst_vec", 32'(b0.vec), 32'h0);
        check("rst_busy", 32'(b0.busy), 32'h0);
        check("rst_done", 32'(b0.done), 32'h0);
        check("rst_pass", 32'(b0.pass), 32'h0);
        check("rst_ones", 32'(b0.ones_a), 32'h0);
        check("rst_mm", 32'(b0.mismatch_cnt), 32'h0);
        check("rst_fmv", 32'(b0.first_mm_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean LAT=0 sweep.
        run_sweep(0, 2000, cyc, ovl);
        check("l0_cycles", 32'(cyc), 32'd1024);
        check("l0_overlap", 32'(ovl), 32'h0);
        check("l0_busy", 32'(b0.busy), 32'h0);
        check("l0_ones", 32'(b0.ones_a), 32'd512);
        check("l0_mm", 32'(b0.mismatch_cnt), 32'd0);
        check("l0_pass", 32'(b0.pass), 32'h1);
        check("l0_fmv", 32'(b0.first_mm_valid), 32'h0);
        check("l0_vec", 32'(b0.vec), 32'h3FF);

        // Single mismatch at 0x2A5, restarted straight from DONE.
        inj0 = 1'b1;
        run_sweep(0, 2000, cyc, ovl);
        check("inj_cycles", 32'(cyc), 32'd1024);
        check("inj_mm", 32'(b0.mismatch_cnt), 32'd1);
        check("inj_fmv", 32'(b0.first_mm_valid), 32'h1);
        check("inj_fvec", 32'(b0.first_mm_vec), 32'h2A5);
        check("inj_pass", 32'(b0.pass), 32'h0);
        check("inj_ones", 32'(b0.ones_a), 32'd512);

        // LAT=2 constant-1 function.
        run_sweep(1, 2000, cyc, ovl);
        check("l2_cycles", 32'(cyc), 32'd1026);
        check("l2_overlap", 32'(ovl), 32'h0);
        check("l2_ones", 32'(b2.ones_a), 32'h400);
        check("l2_mm", 32'(b2.mismatch_cnt), 32'd0);
        check("l2_pass", 32'(b2.pass), 32'h1);

        // LAT=2 with a delayed mismatch: tag alignment must report 0x155.
        inj2 = 1'b1;
        run_sweep(1, 2000, cyc, ovl);
        check("l2inj_cycles", 32'(cyc), 32'd1026);
        check("l2inj_mm", 32'(b2.mismatch_cnt), 32'd1);
        check("l2inj_fvec", 32'(b2.first_mm_vec), 32'h155);
        check("l2inj_pass", 32'(b2.pass), 32'h0);

        // Stop on first mismatch at 0x010.
        run_sweep(2, 2000, cyc, ovl);
        check("stop_cycles", 32'(cyc), 32'd17);
        check("stop_done", 32'(bs.done), 32'h1);
        check("stop_mm", 32'(bs.mismatch_cnt), 32'd1);
        check("stop_fvec", 32'(bs.first_mm_vec), 32'h010);
        check("stop_fmv", 32'(bs.first_mm_valid), 32'h1);

        // Abort at cycle 300 of a run.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        check("abort_busy", 32'(b0.busy), 32'h0);
        check("abort_done", 32'(b0.done), 32'h0);
        check("abort_vec", 32'(b0.vec), 32'd300);
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(b0.busy), 32'h0);
        check("abort_idle_vec", 32'(b0.vec), 32'd300);

        run_sweep(0, 2000, cyc, ovl);
        check("restart_cycles", 32'(cyc), 32'd1024);
        check("restart_ones", 32'(b0.ones_a), 32'd512);
        check("restart_mm", 32'(b0.mismatch_cnt), 32'd1);

        // Abort from DONE, then start+abort together in IDLE.
        @(negedge clk);
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        check("done_abort_done", 32'(b0.done), 32'h0);
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("sa_busy", 32'(b0.busy), 32'h0);
        check("sa_done", 32'(b0.done), 32'h0);
        @(posedge clk);
        #1;
        check("sa_busy2", 32'(b0.busy), 32'h0);

        // Asynchronous reset mid-sweep, then a clean full sweep.
        inj0 = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (500) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(b0.busy), 32'h0);
        check("arst_vec", 32'(b0.vec), 32'h0);
        check("arst_ones", 32'(b0.ones_a), 32'h0);
        check("arst_mm", 32'(b0.mismatch_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 2000, cyc, ovl);
        check("post_rst_cycles", 32'(cyc), 32'd1024);
        check("post_rst_ones", 32'(b0.ones_a), 32'd512);
        check("post_rst_pass", 32'(b0.pass), 32'h1);
        check("post_rst_fmv", 32'(b0.first_mm_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
